// File: rtl/mux_n1_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_n1_scan
// Brief    : Registered N:1 multiplexer with manual select or auto-scan with
//            per-channel dwell, hold and scan-wrap pulse.
// Revision : 1.0
// ============================================================================
module mux_n1_scan #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    parameter int  DWELL    = 4,
    localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      hold,
    input  logic [CHANNELS*WIDTH-1:0] mux_in,
    output logic [WIDTH-1:0]          mux_out,
    output logic [SEL_W-1:0]          ch_out,
    output logic                      out_valid,
    output logic                      scan_wrap
);

    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [0:0]        c_ST_MANUAL  = 1'b0;
    localparam logic [0:0]        c_ST_SCAN    = 1'b1;
    localparam logic [SEL_W:0]    c_NUM_CH     = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0]  c_LAST_CH    = SEL_W'(CHANNELS - 1);
    localparam logic [DCNT_W-1:0] c_DWELL_LAST = DCNT_W'(DWELL - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [SEL_W-1:0]  r_ptr;
    logic [DCNT_W-1:0] r_dcnt;

    logic [SEL_W-1:0]  w_ptr_nxt;
    logic [DCNT_W-1:0] w_dcnt_nxt;
    logic [SEL_W-1:0]  w_idx;
    logic              w_load;
    logic              w_valid;
    logic              w_wrap;
    logic              w_sel_ok;
    logic [SEL_W-1:0]  w_sel_eff;

    logic [WIDTH-1:0]  w_ch [CHANNELS];

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
            assign w_ch[k] = mux_in[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_sel_ok  = ({1'b0, sel} < c_NUM_CH);
    assign w_sel_eff = w_sel_ok ? sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = mode ? c_ST_SCAN : c_ST_MANUAL;
    end

    // The presented channel is the pointer after this edge's update, so the
    // entry edge into scan counts as the first dwell cycle of the start channel.
    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_dcnt_nxt = r_dcnt;
        w_idx      = ch_out;
        w_load     = 1'b0;
        w_valid    = 1'b0;
        w_wrap     = 1'b0;
        case (w_state_nxt)
            c_ST_MANUAL: begin
                if (w_sel_ok) begin
                    w_load  = 1'b1;
                    w_idx   = sel;
                    w_valid = 1'b1;
                end
            end
            c_ST_SCAN: begin
                if (r_state == c_ST_MANUAL) begin
                    w_ptr_nxt  = w_sel_eff;
                    w_dcnt_nxt = '0;
                end else if (!hold) begin
                    if (r_dcnt == c_DWELL_LAST) begin
                        w_dcnt_nxt = '0;
                        if (r_ptr == c_LAST_CH) begin
                            w_ptr_nxt = '0;
                            w_wrap    = 1'b1;
                        end else begin
                            w_ptr_nxt = r_ptr + SEL_W'(1);
                        end
                    end else begin
                        w_dcnt_nxt = r_dcnt + DCNT_W'(1);
                    end
                end
                w_load  = 1'b1;
                w_idx   = w_ptr_nxt;
                w_valid = 1'b1;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_dcnt    <= '0;
            mux_out   <= '0;
            ch_out    <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_dcnt    <= w_dcnt_nxt;
            out_valid <= w_valid;
            scan_wrap <= w_wrap;
            if (w_load) begin
                mux_out <= w_ch[w_idx];
                ch_out  <= w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_n1_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_n1_scan
// Brief    : Directed and randomized checks of mux_n1_scan against a
//            cycle-level behavioural model, on two parameter sets.
// Revision : 1.0
// ============================================================================
module tb_mux_n1_scan;

    typedef struct {
        bit         scan;
        int         ptr;
        int         spent;
        logic [7:0] out;
        int         ch;
        bit         valid;
        bit         wrap;
    } mdl_t;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic        hold;
    logic [31:0] mux_in_a;
    logic [23:0] mux_in_b;
    logic [7:0]  mux_out_a, mux_out_b;
    logic [1:0]  ch_out_a, ch_out_b;
    logic        out_valid_a, out_valid_b;
    logic        scan_wrap_a, scan_wrap_b;

    int compared = 0;
    int mismatched = 0;
    mdl_t ma, mb;

    mux_n1_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .hold(hold),
        .mux_in(mux_in_a), .mux_out(mux_out_a), .ch_out(ch_out_a),
        .out_valid(out_valid_a), .scan_wrap(scan_wrap_a)
    );

    mux_n1_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .hold(hold),
        .mux_in(mux_in_b), .mux_out(mux_out_b), .ch_out(ch_out_b),
        .out_valid(out_valid_b), .scan_wrap(scan_wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "spent" is the number of output cycles already shown on ptr.
    function automatic mdl_t mstep(mdl_t m, int nch, int dwell, bit md, int s,
                                   bit hd, logic [31:0] d);
        mdl_t r;
        r = m;
        r.wrap = 1'b0;
        if (!md) begin
            r.scan = 1'b0;
            if (s < nch) begin
                r.out   = d[s*8 +: 8];
                r.ch    = s;
                r.valid = 1'b1;
            end else begin
                r.valid = 1'b0;
            end
        end else begin
            if (!m.scan) begin
                r.ptr   = (s < nch) ? s : 0;
                r.spent = 1;
            end else if (!hd) begin
                if (m.spent >= dwell) begin
                    r.ptr   = (m.ptr + 1) % nch;
                    r.spent = 1;
                    r.wrap  = (r.ptr == 0);
                end else begin
                    r.spent = m.spent + 1;
                end
            end
            r.scan  = 1'b1;
            r.out   = d[r.ptr*8 +: 8];
            r.ch    = r.ptr;
            r.valid = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_out",  32'(mux_out_a),   32'(ma.out));
        chk("a_ch",   32'(ch_out_a),    ma.ch);
        chk("a_vld",  32'(out_valid_a), 32'(ma.valid));
        chk("a_wrap", 32'(scan_wrap_a), 32'(ma.wrap));
        chk("b_out",  32'(mux_out_b),   32'(mb.out));
        chk("b_ch",   32'(ch_out_b),    mb.ch);
        chk("b_vld",  32'(out_valid_b), 32'(mb.valid));
        chk("b_wrap", 32'(scan_wrap_b), 32'(mb.wrap));
    endtask

    task automatic step();
        @(posedge clk);
        ma = mstep(ma, 4, 2, mode, int'(sel), hold, mux_in_a);
        mb = mstep(mb, 3, 1, mode, int'(sel), hold, {8'h00, mux_in_b});
        #1;
        check_all();
    endtask

    task automatic reset_models();
        ma = '{default: 0};
        mb = '{default: 0};
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        reset_models();
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp33 [9];
        int exp35 [5];
        int n;
        exp33 = '{1, 1, 2, 2, 3, 3, 0, 0, 1};
        exp35 = '{0, 1, 2, 0, 1};

        rst_n    = 1'b0;
        mode     = 1'b0;
        sel      = 2'd2;
        hold     = 1'b0;
        mux_in_a = 32'hD3C2B1A0;
        mux_in_b = 24'hC2B1A0;
        #2;
        reset_models();
        check_all();
        #1 rst_n = 1'b1;

        step();
        chk("r31_out", 32'(mux_out_a), 32'hC2);
        chk("r31_ch",  32'(ch_out_a), 32'd2);
        chk("r31_vld", 32'(out_valid_a), 32'd1);
        async_reset();
        chk("r31_async_out", 32'(mux_out_a), 32'h0);
        step();

        sel = 2'd1; step();
        chk("r32_b_out", 32'(mux_out_b), 32'hB1);
        sel = 2'd3; step();
        chk("r32_b_hold_out", 32'(mux_out_b), 32'hB1);
        chk("r32_b_hold_ch",  32'(ch_out_b), 32'd1);
        chk("r32_b_hold_vld", 32'(out_valid_b), 32'd0);
        sel = 2'd0; step();
        chk("r32_b_sel0_out", 32'(mux_out_b), 32'hA0);
        chk("r32_b_sel0_vld", 32'(out_valid_b), 32'd1);

        mode = 1'b1; sel = 2'd1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("r33_ch",   32'(ch_out_a), exp33[i]);
            chk("r33_wrap", 32'(scan_wrap_a), 32'(i == 6));
        end

        n = 0;
        while (ch_out_a != 2'd2 && n < 10) begin
            step();
            n++;
        end
        chk("r34_seek_ch2", 32'(ch_out_a), 32'd2);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) mux_in_a[23:16] = 8'h55;
            step();
            chk("r34_hold_ch", 32'(ch_out_a), 32'd2);
            chk("r34_hold_wrap", 32'(scan_wrap_a), 32'd0);
            if (i >= 2) chk("r34_live_data", 32'(mux_out_a), 32'h55);
        end
        hold = 1'b0;
        step();
        chk("r34_resume_ch", 32'(ch_out_a), 32'd2);
        step();
        chk("r34_advance_ch", 32'(ch_out_a), 32'd3);
        mux_in_a = 32'hD3C2B1A0;

        mode = 1'b0; sel = 2'd0; step();
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r35_ch",   32'(ch_out_b), exp35[i]);
            chk("r35_wrap", 32'(scan_wrap_b), 32'(i == 3));
        end
        mode = 1'b0; sel = 2'd2; step();
        chk("r35_manual_ch",   32'(ch_out_b), 32'd2);
        chk("r35_manual_wrap", 32'(scan_wrap_b), 32'd0);

        mode = 1'b1; sel = 2'd0;
        n = 0;
        while (ch_out_a != 2'd3 && n < 12) begin
            step();
            n++;
        end
        chk("r36_seek_ch3", 32'(ch_out_a), 32'd3);
        async_reset();
        chk("r36_async_ch", 32'(ch_out_a), 32'd0);
        step(); chk("r36_ch0a", 32'(ch_out_a), 32'd0);
        step(); chk("r36_ch0b", 32'(ch_out_a), 32'd0);
        step(); chk("r36_ch1",  32'(ch_out_a), 32'd1);

        for (int i = 0; i < 400; i++) begin
            mode     = ($urandom_range(0, 3) != 0);
            sel      = 2'($urandom_range(0, 3));
            hold     = ($urandom_range(0, 3) == 0);
            mux_in_a = $urandom;
            mux_in_b = 24'($urandom);
            step();
            if ($urandom_range(0, 49) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_n1_scan.md
MUX_N1_SCAN -- requirements
Module: mux_n1_scan

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (>=2).
REQ-003 Parameter DWELL, default 4, scan-mode cycles spent on each channel (>=1).
REQ-004 Derived localparam SEL_W = max(1, clog2(CHANNELS)), the select and index width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-008 sel  input  SEL_W  manual channel select; also the scan start channel.
REQ-009 hold  input  1  freezes scan advance when high in scan mode; ignored in manual mode.
REQ-010 mux_in  input  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 mux_out  output  WIDTH  registered selected data.
REQ-012 ch_out  output  SEL_W  index of the channel currently presented on mux_out.
REQ-013 out_valid  output  1  high when mux_out/ch_out hold data from a legal channel.
REQ-014 scan_wrap  output  1  one-cycle pulse when the scan pointer wraps from CHANNELS-1 to 0.

Function
REQ-015 The block shall have two states, MANUAL and SCAN, with the state register loaded from mode every cycle.
REQ-016 All outputs shall be registered; mux_out/ch_out reflect the selection made on the previous edge (1-cycle latency).
REQ-017 MANUAL with sel < CHANNELS: next mux_out = channel sel, ch_out = sel, out_valid = 1.
REQ-018 MANUAL with sel >= CHANNELS: mux_out and ch_out hold their previous values, out_valid = 0 for that cycle.
REQ-019 SCAN uses internal pointer ptr (SEL_W) and dwell counter dcnt; next mux_out = channel ptr, ch_out = ptr, out_valid = 1.
REQ-020 SCAN, hold low: dcnt increments each cycle; when dcnt == DWELL-1, dcnt -> 0 and ptr advances by 1.
REQ-021 Pointer advance from CHANNELS-1 shall wrap to 0 (including non-power-of-2 CHANNELS) and assert scan_wrap for exactly that cycle.
REQ-022 SCAN, hold high: ptr and dcnt frozen, scan_wrap = 0, mux_out keeps sampling the live channel ptr each cycle.
REQ-023 DWELL = 1 shall advance ptr every cycle not held.
REQ-024 MANUAL -> SCAN transition (mode 0->1 sampled): ptr loads sel (0 if sel >= CHANNELS), dcnt loads 0; first scan output is that channel.
REQ-025 SCAN -> MANUAL transition: manual selection applies from the same edge; ptr/dcnt retain value, unused.
REQ-026 Input data changes on the selected channel shall appear on mux_out one cycle later, independent of dwell position.
REQ-027 scan_wrap shall be 0 at all times in MANUAL.

Reset
REQ-028 rst_n low shall immediately (asynchronously) force mux_out = 0, ch_out = 0, out_valid = 0, scan_wrap = 0, ptr = 0, dcnt = 0, state = MANUAL.
REQ-029 Reset asserted mid-scan or mid-dwell shall discard progress; after release, behaviour follows REQ-017..REQ-024 from the first rising edge, with the mode 0->1 rule applied if mode is high.
REQ-030 Reset release shall be synchronised by the integrator; the block adds no internal synchroniser.

Verification (WIDTH=8, CHANNELS=4, DWELL=2 unless stated; mux_in = {8'hD3,8'hC2,8'hB1,8'hA0})
REQ-031 Reset: rst_n low mid-cycle -> all outputs 0 without waiting for clk; release, mode=0, sel=2 -> next edge mux_out=8'hC2, ch_out=2, out_valid=1.
REQ-032 Manual illegal select: CHANNELS=3, sel=3 after sel=1 -> mux_out stays 8'hB1, ch_out=1, out_valid=0; sel=0 -> 8'hA0, out_valid=1.
REQ-033 Scan sequence: mode=1, sel=1 -> ch_out 1,1,2,2,3,3,0,0,1; scan_wrap high only on the first cycle ch_out=0.
REQ-034 Hold: during scan assert hold for 5 cycles on ch 2 -> ch_out stays 2, change channel-2 data to 8'h55 during hold -> mux_out=8'h55 next cycle; release -> dwell resumes from frozen dcnt.
REQ-035 DWELL=1, CHANNELS=3: ch_out 0,1,2,0,1 with scan_wrap each third cycle; mode 1->0 with sel=2 -> ch_out=2 next cycle, scan_wrap=0.
REQ-036 Reset mid-scan at ch 3: outputs 0 asynchronously; release with mode=1, sel=0 -> scan restarts at ch 0 with full DWELL.
